// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and RAM-side signals around mem_arbiter.
// The master side is the requesters plus the RAM; the slave side is the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;
    logic              ls_wdone;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_w_en;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              busy;

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ram_rdata,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_wdone,
               ram_addr, ram_w_en, ram_wdata, busy
    );

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ram_rdata,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_wdone,
               ram_addr, ram_w_en, ram_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM between instruction fetch
// and load/store; one access per ISSUE cycle, response in the following RESP cycle.
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE_IF = 3'd1,
        ISSUE_LS = 3'd2,
        RESP_IF  = 3'd3,
        RESP_LS  = 3'd4
    } state_t;

    state_t state_reg, state_next, arb_state;
    logic   last_ls_reg, last_ls_next;
    logic   wr_q_reg, wr_q_next;

    // last_ls resets to 1 so the fetch side wins the first conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            last_ls_reg <= 1'b1;
            wr_q_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            last_ls_reg <= last_ls_next;
            wr_q_reg    <= wr_q_next;
        end
    end

    always_comb begin
        arb_state = IDLE;
        if (bus.if_req && (!bus.ls_req || last_ls_reg)) begin
            arb_state = ISSUE_IF;
        end else if (bus.ls_req) begin
            arb_state = ISSUE_LS;
        end
    end

    always_comb begin
        state_next    = state_reg;
        last_ls_next  = last_ls_reg;
        wr_q_next     = wr_q_reg;
        bus.if_gnt    = 1'b0;
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = {DATA_W{1'b0}};
        bus.ls_gnt    = 1'b0;
        bus.ls_rvalid = 1'b0;
        bus.ls_rdata  = {DATA_W{1'b0}};
        bus.ls_wdone  = 1'b0;
        bus.ram_addr  = {ADDR_W{1'b0}};
        bus.ram_w_en  = 1'b0;
        bus.ram_wdata = {DATA_W{1'b0}};
        bus.busy      = 1'b0;

        unique case (state_reg)
            IDLE: begin
                state_next = arb_state;
            end
            ISSUE_IF: begin
                bus.busy     = 1'b1;
                bus.if_gnt   = 1'b1;
                bus.ram_addr = bus.if_addr;
                state_next   = RESP_IF;
                last_ls_next = 1'b0;
            end
            ISSUE_LS: begin
                bus.busy      = 1'b1;
                bus.ls_gnt    = 1'b1;
                bus.ram_addr  = bus.ls_addr;
                bus.ram_w_en  = bus.ls_we;
                bus.ram_wdata = bus.ls_we ? bus.ls_wdata : {DATA_W{1'b0}};
                state_next    = RESP_LS;
                last_ls_next  = 1'b1;
                wr_q_next     = bus.ls_we;
            end
            RESP_IF: begin
                // The response overlaps arbitration for the next access.
                bus.busy      = 1'b1;
                bus.if_rvalid = 1'b1;
                bus.if_rdata  = bus.ram_rdata;
                state_next    = arb_state;
            end
            RESP_LS: begin
                bus.busy = 1'b1;
                if (wr_q_reg) begin
                    bus.ls_wdone = 1'b1;
                end else begin
                    bus.ls_rvalid = 1'b1;
                    bus.ls_rdata  = bus.ram_rdata;
                end
                state_next = arb_state;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers queue requests, a negedge monitor
// checks grants, responses and fairness against a transaction-level memory model.
module tb_mem_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Physical synchronous RAM seen by the arbiter.
    logic [DW-1:0] ram [256];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (bus.ram_w_en) ram[bus.ram_addr] <= bus.ram_wdata;
        ram_q <= ram[bus.ram_addr];
    end
    assign bus.ram_rdata = ram_q;

    // Reference memory, updated whenever a write is granted.
    logic [DW-1:0] ref_mem [256];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct packed {
        int            due;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } rsp_t;

    req_t if_pend[$];
    req_t ls_pend[$];
    rsp_t if_rsp[$];
    rsp_t ls_rsp[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic ok,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_all_zero(input string name);
        logic [62:0] v;
        v = {bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.ls_gnt, bus.ls_rvalid,
             bus.ls_rdata, bus.ls_wdone, bus.ram_addr, bus.ram_w_en, bus.ram_wdata, bus.busy};
        check(name, v == '0, 32'(v), 32'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    int   cyc = 0;
    bit   prev_gnt, prev_if, prev_ls, last_gnt_ls;
    req_t r;
    rsp_t e;

    always @(negedge clk) begin
        if (!rst_n) begin
            if_pend.delete(); ls_pend.delete();
            if_rsp.delete();  ls_rsp.delete();
            last_gnt_ls = 1'b1;
            prev_gnt = 1'b1; prev_if = 1'b0; prev_ls = 1'b0;
        end else begin
            cyc++;
            check("one_gnt", !(bus.if_gnt && bus.ls_gnt), {30'd0, bus.if_gnt, bus.ls_gnt}, 32'd1);
            check("busy", bus.busy == (bus.if_gnt | bus.ls_gnt | bus.if_rvalid | bus.ls_rvalid | bus.ls_wdone),
                  32'(bus.busy), 32'(!bus.busy));

            if (bus.if_gnt) begin
                check("if_gnt_expected", if_pend.size() != 0, 32'(if_pend.size()), 32'd1);
                if (if_pend.size() != 0) begin
                    r = if_pend.pop_front();
                    check("if_gnt_bus", {bus.ram_addr, bus.ram_w_en} == {r.addr, 1'b0},
                          32'({bus.ram_addr, bus.ram_w_en}), 32'({r.addr, 1'b0}));
                    if_rsp.push_back('{due: cyc + 1, wr: 1'b0, addr: r.addr, data: ref_mem[r.addr]});
                end
                if (prev_if && prev_ls) check("fair_if", last_gnt_ls == 1'b1, 32'(last_gnt_ls), 32'd1);
                last_gnt_ls = 1'b0;
            end
            if (bus.ls_gnt) begin
                check("ls_gnt_expected", ls_pend.size() != 0, 32'(ls_pend.size()), 32'd1);
                if (ls_pend.size() != 0) begin
                    r = ls_pend.pop_front();
                    check("ls_gnt_bus",
                          {bus.ram_addr, bus.ram_w_en, bus.ram_wdata} == {r.addr, r.we, r.we ? r.wdata : 16'h0},
                          32'({bus.ram_addr, bus.ram_w_en, bus.ram_wdata}),
                          32'({r.addr, r.we, r.we ? r.wdata : 16'h0}));
                    if (r.we) ref_mem[r.addr] = r.wdata;
                    ls_rsp.push_back('{due: cyc + 1, wr: r.we, addr: r.addr, data: ref_mem[r.addr]});
                end
                if (prev_if && prev_ls) check("fair_ls", last_gnt_ls == 1'b0, 32'(last_gnt_ls), 32'd0);
                last_gnt_ls = 1'b1;
            end
            if (!bus.if_gnt && !bus.ls_gnt) begin
                check("bus_idle", {bus.ram_addr, bus.ram_w_en, bus.ram_wdata} == '0,
                      32'({bus.ram_addr, bus.ram_w_en, bus.ram_wdata}), 32'd0);
            end
            if (!prev_gnt && (prev_if || prev_ls)) begin
                check("gnt_latency", bus.if_gnt || bus.ls_gnt, 32'd0, 32'd1);
            end

            if (bus.if_rvalid) begin
                check("if_resp_expected", if_rsp.size() != 0, 32'(if_rsp.size()), 32'd1);
                if (if_rsp.size() != 0) begin
                    e = if_rsp.pop_front();
                    check("if_resp_cycle", e.due == cyc, 32'(cyc), 32'(e.due));
                    check("if_rdata", bus.if_rdata == e.data, 32'(bus.if_rdata), 32'(e.data));
                    $display("%0t IF rd  addr=%02h data=%04h", $time, e.addr, bus.if_rdata);
                end
            end else begin
                check("if_rdata_zero", bus.if_rdata == '0, 32'(bus.if_rdata), 32'd0);
                if (if_rsp.size() != 0) begin
                    check("if_resp_pending", if_rsp[0].due > cyc, 32'(cyc), 32'(if_rsp[0].due));
                    if (if_rsp[0].due <= cyc) void'(if_rsp.pop_front());
                end
            end

            if (bus.ls_rvalid || bus.ls_wdone) begin
                check("ls_pulse_excl", !(bus.ls_rvalid && bus.ls_wdone),
                      {30'd0, bus.ls_rvalid, bus.ls_wdone}, 32'd1);
                check("ls_resp_expected", ls_rsp.size() != 0, 32'(ls_rsp.size()), 32'd1);
                if (ls_rsp.size() != 0) begin
                    e = ls_rsp.pop_front();
                    check("ls_resp_cycle", e.due == cyc, 32'(cyc), 32'(e.due));
                    check("ls_resp_kind", bus.ls_wdone == e.wr, 32'(bus.ls_wdone), 32'(e.wr));
                    if (!e.wr) check("ls_rdata", bus.ls_rdata == e.data, 32'(bus.ls_rdata), 32'(e.data));
                    $display("%0t LS %s addr=%02h data=%04h", $time, e.wr ? "wr" : "rd", e.addr,
                             e.wr ? e.data : bus.ls_rdata);
                end
            end else if (ls_rsp.size() != 0) begin
                check("ls_resp_pending", ls_rsp[0].due > cyc, 32'(cyc), 32'(ls_rsp[0].due));
                if (ls_rsp[0].due <= cyc) void'(ls_rsp.pop_front());
            end
            if (!bus.ls_rvalid) check("ls_rdata_zero", bus.ls_rdata == '0, 32'(bus.ls_rdata), 32'd0);

            prev_gnt = bus.if_gnt | bus.ls_gnt;
            prev_if  = bus.if_req;
            prev_ls  = bus.ls_req;
        end
    end

    // ---------------- drivers ----------------
    task automatic if_access(input logic [AW-1:0] a);
        bit got = 1'b0;
        bus.if_addr = a;
        bus.if_req  = 1'b1;
        if_pend.push_back('{addr: a, we: 1'b0, wdata: '0});
        for (int k = 0; k < 16 && !got; k++) begin
            @(negedge clk);
            got = bus.if_gnt;
        end
        check("if_gnt_timeout", got, 32'(got), 32'd1);
        @(posedge clk); #1;
        bus.if_req = 1'b0;
    endtask

    task automatic ls_access(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd);
        bit got = 1'b0;
        bus.ls_addr  = a;
        bus.ls_we    = we;
        bus.ls_wdata = wd;
        bus.ls_req   = 1'b1;
        ls_pend.push_back('{addr: a, we: we, wdata: wd});
        for (int k = 0; k < 16 && !got; k++) begin
            @(negedge clk);
            got = bus.ls_gnt;
        end
        check("ls_gnt_timeout", got, 32'(got), 32'd1);
        @(posedge clk); #1;
        bus.ls_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic reset_now(input string name);
        rst_n = 1'b0;
        #1 check_all_zero(name);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
    endtask

    task automatic if_random(input int n);
        for (int i = 0; i < n; i++) begin
            idle($urandom_range(0, 3));
            if_access(AW'($urandom_range(0, 15)));
        end
    endtask

    task automatic ls_random(input int n);
        for (int i = 0; i < n; i++) begin
            idle($urandom_range(0, 3));
            ls_access(AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), DW'($urandom));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            ram[i]     <= DW'(i * 16'h0101) ^ 16'h5a5a;
            ref_mem[i]  = DW'(i * 16'h0101) ^ 16'h5a5a;
        end
        ram[5]     <= 16'h1234;
        ref_mem[5]  = 16'h1234;

        @(posedge clk); #1;
        check_all_zero("reset_outputs");
        idle(2);
        rst_n = 1'b1;
        idle(4);

        // Single fetch, then store/load of the same word.
        if_access(8'h05);
        idle(2);
        ls_access(8'h0a, 1'b1, 16'hbeef);
        ls_access(8'h0a, 1'b0, 16'h0000);
        idle(2);

        // Simultaneous first requests: fetch first, then strict alternation.
        fork
            begin for (int i = 0; i < 4; i++) if_access(AW'(8'h20 + i)); end
            begin for (int i = 0; i < 4; i++) ls_access(AW'(8'h40 + i), 1'(i % 2), DW'(16'h1000 + i)); end
        join
        idle(2);

        // Back-to-back fetches with changing addresses.
        for (int i = 0; i < 3; i++) if_access(AW'(8'h05 + i));
        idle(2);

        // Reset while a fetch is on the RAM port.
        bus.if_addr = 8'h33; bus.if_req = 1'b1;
        if_pend.push_back('{addr: 8'h33, we: 1'b0, wdata: '0});
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin @(negedge clk); got = bus.if_gnt; end
        check("rst_issue_gnt", got, 32'(got), 32'd1);
        #1 bus.if_req = 1'b0;
        reset_now("rst_issue");

        // Reset during the response cycle of a load: no ls_rvalid may follow.
        bus.ls_addr = 8'h05; bus.ls_we = 1'b0; bus.ls_req = 1'b1;
        ls_pend.push_back('{addr: 8'h05, we: 1'b0, wdata: '0});
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin @(negedge clk); got = bus.ls_gnt; end
        check("rst_resp_gnt", got, 32'(got), 32'd1);
        @(posedge clk); #1 bus.ls_req = 1'b0;
        #1 reset_now("rst_resp_ls");

        // After reset the fetch side must win a conflict again.
        fork
            if_access(8'h07);
            ls_access(8'h08, 1'b0, 16'h0000);
        join
        idle(2);

        fork
            if_random(40);
            ls_random(40);
        join
        idle(4);

        check("drain", (if_pend.size() + ls_pend.size() + if_rsp.size() + ls_rsp.size()) == 0,
              32'(if_pend.size() + ls_pend.size() + if_rsp.size() + ls_rsp.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
